// File: rtl/ofs_fim_eth_tx_sf_buffer.sv
// Purpose : store-and-forward TX packet buffer; a packet goes to the MAC only once its last beat is stored.
// Latency : tlast accepted at edge N -> first beat on m_tvalid at edge N+2 at the earliest (empty, m_tready=1).
// Backpr. : s_tready=0 while full (oversize packets are swallowed instead); m_* holds stable while m_tready=0.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast/s_tuser_err   upstream AXI-S (err sampled on tlast)
//   m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast/m_tuser_err   downstream AXI-S to the MAC
//   pkt_cnt                          complete packets held (committed, tlast not yet handed off)
//   drop_cnt                         saturating count of discarded packets
// Build option: define OFS_FIM_ETH_TX_SF_ERR_DROP_EN to discard packets flagged with s_tuser_err
// instead of forwarding them (m_tuser_err is then constant 0).

module ofs_fim_eth_tx_sf_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_W-1:0]       s_tdata,
    input  logic [DATA_W/8-1:0]     s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tuser_err,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic [DATA_W/8-1:0]     m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tuser_err,
    output logic [$clog2(DEPTH):0]  pkt_cnt,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int KW = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = DATA_W + KW + 2;    // {tdata, tkeep, tlast, err}
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DROP
    } wr_state_t;

    wr_state_t         state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]     rd_ptr_q;        // retired at the m-side handshake
    logic [PW-1:0]     fetch_ptr_q;     // next RAM word to read
    logic              rdy_en_q;
    logic [PW-1:0]     pkt_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    logic              full;
    logic              oversize;
    logic              wr_en;
    logic              commit;
    logic              drop_inc;
    logic              err_bit;

    logic [RW-1:0]     mem [DEPTH];
    logic [RW-1:0]     s1_dat_q;
    logic              s1_vld_q;
    logic [RW-1:0]     m_dat_q;
    logic              m_vld_q;
    logic [RW-1:0]     sk_dat_q;
    logic              sk_vld_q;

    logic              pop;
    logic              push;
    logic              fetch;
    logic [1:0]        occ;
    logic [1:0]        occ_after;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    // Occupancy is measured against rd_ptr, which only moves on the output
    // handshake, so beats sitting in the read pipeline still count as held.
    assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    // With no complete packet held, a full buffer can only mean the packet
    // being written is larger than the buffer: it can never be released.
    assign oversize = (state_q != ST_DROP) && full && (pkt_cnt_q == '0);

`ifdef OFS_FIM_ETH_TX_SF_ERR_DROP_EN
    assign err_bit = 1'b0;
`else
    assign err_bit = s_tlast & s_tuser_err;
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        s_tready     = 1'b0;
        wr_en        = 1'b0;
        commit       = 1'b0;
        drop_inc     = 1'b0;
        if (rdy_en_q) begin
            if (oversize) begin
                // Rewind and swallow the rest of the packet; the beat offered
                // now is accepted and discarded.
                s_tready = 1'b1;
                wr_ptr_d = commit_ptr_q;
                if (s_tvalid && s_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_DROP;
                end
            end else begin
                case (state_q)
                    ST_DROP: begin
                        s_tready = 1'b1;
                        if (s_tvalid && s_tlast) begin
                            drop_inc = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                    default: begin
                        s_tready = !full;
                        if (s_tvalid && !full) begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            if (s_tlast) begin
                                state_d = ST_IDLE;
`ifdef OFS_FIM_ETH_TX_SF_ERR_DROP_EN
                                if (s_tuser_err) begin
                                    wr_ptr_d = commit_ptr_q;
                                    drop_inc = 1'b1;
                                end else begin
                                    commit       = 1'b1;
                                    commit_ptr_d = wr_ptr_q + PW'(1);
                                end
`else
                                commit       = 1'b1;
                                commit_ptr_d = wr_ptr_q + PW'(1);
`endif
                            end else begin
                                state_d = ST_FILL;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: fetch -> s1 (RAM output register) -> 2-entry skid (m, sk)
    // ------------------------------------------------------------------
    // Only committed words are fetched, so once a packet starts it is fully
    // available and the pipeline never starves mid-packet.  At most three
    // beats are in flight (s1 + m + sk), so a fetched word always has a home.
    assign pop       = m_vld_q & m_tready;
    assign push      = s1_vld_q & !(sk_vld_q & !pop);
    assign occ       = 2'(s1_vld_q) + 2'(m_vld_q) + 2'(sk_vld_q);
    assign occ_after = occ - 2'(pop);
    assign fetch     = (fetch_ptr_q != commit_ptr_q) && (occ_after != 2'd3);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_tdata, s_tkeep, s_tlast, err_bit};
        end
        if (fetch) begin
            s1_dat_q <= mem[fetch_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            rdy_en_q     <= 1'b0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            s1_vld_q     <= 1'b0;
            m_vld_q      <= 1'b0;
            m_dat_q      <= '0;
            sk_vld_q     <= 1'b0;
            sk_dat_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_q + PW'(pop);
            fetch_ptr_q  <= fetch_ptr_q + PW'(fetch);
            rdy_en_q     <= 1'b1;

            case ({commit, pop & m_tlast})
                2'b10:   pkt_cnt_q <= pkt_cnt_q + PW'(1);
                2'b01:   pkt_cnt_q <= pkt_cnt_q - PW'(1);
                default: pkt_cnt_q <= pkt_cnt_q;
            endcase

            if (drop_inc && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end

            s1_vld_q <= fetch | (s1_vld_q & !push);

            if (pop) begin
                if (sk_vld_q) begin
                    m_dat_q  <= sk_dat_q;
                    sk_vld_q <= push;
                    if (push) begin
                        sk_dat_q <= s1_dat_q;
                    end
                end else begin
                    m_vld_q <= push;
                    if (push) begin
                        m_dat_q <= s1_dat_q;
                    end
                end
            end else if (!m_vld_q) begin
                m_vld_q <= push;
                if (push) begin
                    m_dat_q <= s1_dat_q;
                end
            end else if (push) begin
                sk_vld_q <= 1'b1;
                sk_dat_q <= s1_dat_q;
            end
        end
    end

    assign m_tvalid = m_vld_q;
    assign m_tdata  = m_dat_q[RW-1 -: DATA_W];
    assign m_tkeep  = m_dat_q[KW+1 : 2];
    assign m_tlast  = m_dat_q[1];
`ifdef OFS_FIM_ETH_TX_SF_ERR_DROP_EN
    assign m_tuser_err = 1'b0;
`else
    assign m_tuser_err = m_dat_q[0];
`endif
    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ofs_fim_eth_tx_sf_buffer.sv
// Purpose : directed + small randomised bench for the TX store-and-forward buffer (DEPTH=16).
// Latency : checks first-beat timing of an isolated packet at tlast edge + 2.
// Backpr. : exercises m_tready stalls, oversize drop, full stall and mid-packet reset.

module tb_ofs_fim_eth_tx_sf_buffer;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int KW     = DATA_W / 8;
    localparam int PCW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [DATA_W-1:0] s_tdata = '0;
    logic [KW-1:0]     s_tkeep = '0;
    logic              s_tlast = 1'b0;
    logic              s_tuser_err = 1'b0;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [DATA_W-1:0] m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic              m_tuser_err;
    logic [PCW-1:0]    pkt_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    ofs_fim_eth_tx_sf_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tuser_err (s_tuser_err),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .m_tuser_err (m_tuser_err),
        .pkt_cnt     (pkt_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // m_tready: fixed level or random, updated just after each rising edge
    bit rdy_fixed = 1'b0;
    bit rdy_rand  = 1'b0;
    always @(posedge clk) begin
        #1;
        m_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end

    // Expected output beats: {tdata, tkeep, tlast, err}
    logic [DATA_W+KW+1:0] exp_q[$];

    int pkt_id         = 1;
    int acc_cnt        = 0;
    int stall_cnt      = 0;
    int tlast_edge     = 0;
    int first_vld_edge = -1;
    int vld_seen       = 0;
    int beats_out      = 0;
    int gap_cnt        = 0;
    int run            = 0;
    int last_run       = 0;
    bit in_pkt         = 1'b0;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [DATA_W+KW+1:0] e;
        if (!rst_n) begin
            in_pkt = 1'b0;
            run    = 0;
        end else begin
            if (m_tvalid) begin
                run++;
                vld_seen++;
                if (first_vld_edge < 0) first_vld_edge = cyc;
            end else begin
                if (run != 0) last_run = run;
                run = 0;
            end
            if (in_pkt && !m_tvalid) gap_cnt++;
            if (m_tvalid && m_tready) begin
                beats_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_tdata", m_tdata, e[DATA_W+KW+1 -: DATA_W]);
                    chk("m_keep_last_err", {m_tkeep, m_tlast, m_tuser_err}, e[KW+1:0]);
                end
                in_pkt = !m_tlast;
            end
        end
    end

    // Drive one packet; data = {pkt_id, beat index}, last-beat keep varies.
    task automatic send_pkt(input int len, input int gap, input bit err, input bit expect_out);
        logic [DATA_W-1:0] d;
        logic [KW-1:0]     k;
        bit                last;
        int                n;
        for (int i = 0; i < len; i++) begin
            last = (i == len - 1);
            d    = {32'(pkt_id), 32'(i)};
            k    = last ? (8'hFF >> (pkt_id % 8)) : 8'hFF;
            s_tvalid    = 1'b1;
            s_tdata     = d;
            s_tkeep     = k;
            s_tlast     = last;
            s_tuser_err = err && last;
            n = 0;
            forever begin
                @(negedge clk);
                if (s_tready) break;
                stall_cnt++;
                n++;
                if (n > 500) begin
                    chk("accept_timeout", 64'd0, 64'd1);
                    break;
                end
            end
            acc_cnt++;
            if (last) tlast_edge = cyc + 1;
            if (expect_out) exp_q.push_back({d, k, last, err && last});
            @(posedge clk);
            #1;
            s_tvalid    = 1'b0;
            s_tlast     = 1'b0;
            s_tuser_err = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        pkt_id++;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || m_tvalid) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                chk("drain_timeout", 64'(exp_q.size()), 64'd0);
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acc0;
        int drop0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_keep_last_err", {m_tkeep, m_tlast, m_tuser_err}, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_tready_before_edge", s_tready, 0);
        @(posedge clk);
        #1;
        chk("s_tready_after_edge", s_tready, 1);

        // ---------------- single 4-beat packet, latency ----------------
        rdy_fixed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        first_vld_edge = -1;
        send_pkt(4, 0, 1'b0, 1'b1);
        chk("pkt_cnt_after_commit", pkt_cnt, 1);
        wait_drain();
        chk("first_beat_latency", 64'(first_vld_edge - tlast_edge), 64'd2);
        chk("run_4beat", 64'(last_run), 64'd4);
        chk("pkt_cnt_after_drain", pkt_cnt, 0);

        // ---------------- 8 beats with 3-cycle source gaps ----------------
        send_pkt(8, 3, 1'b0, 1'b1);
        wait_drain();
        chk("run_8beat_gapped", 64'(last_run), 64'd8);

        // ---------------- oversize packet dropped ----------------
        rdy_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vld_seen  = 0;
        stall_cnt = 0;
        send_pkt(20, 0, 1'b0, 1'b0);
        chk("oversize_no_stall", 64'(stall_cnt), 64'd0);
        chk("oversize_drop_cnt", drop_cnt, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("oversize_no_m_tvalid", 64'(vld_seen), 64'd0);
        rdy_fixed = 1'b1;
        send_pkt(2, 0, 1'b0, 1'b1);
        wait_drain();
        chk("after_drop_pkt_cnt", pkt_cnt, 0);

        // ---------------- fill with 3x5 beats, 4th stalls ----------------
        rdy_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) send_pkt(5, 0, 1'b0, 1'b1);
        chk("three_pkts_pkt_cnt", pkt_cnt, 3);
        chk("three_pkts_s_tready", s_tready, 1);
        acc0 = acc_cnt;
        fork
            send_pkt(5, 0, 1'b0, 1'b1);
            begin
                repeat (10) @(posedge clk);
                #2;
                chk("fourth_stall_s_tready", s_tready, 0);
                chk("fourth_beats_accepted", 64'(acc_cnt - acc0), 64'd1);
                rdy_fixed = 1'b1;
            end
        join
        wait_drain();
        chk("fill_drained_pkt_cnt", pkt_cnt, 0);

        // ---------------- errored packet ----------------
        drop0 = drop_cnt;
`ifdef OFS_FIM_ETH_TX_SF_ERR_DROP_EN
        send_pkt(3, 0, 1'b1, 1'b0);
        wait_drain();
        chk("err_pkt_dropped", drop_cnt, 64'(drop0 + 1));
`else
        send_pkt(3, 0, 1'b1, 1'b1);
        wait_drain();
        chk("err_pkt_forwarded_drop_cnt", drop_cnt, 64'(drop0));
`endif

        // ---------------- 2*DEPTH single-beat packets (wrap) ----------------
        for (int p = 0; p < 2 * DEPTH; p++) send_pkt(1, 0, 1'b0, 1'b1);
        wait_drain();
        chk("single_beat_pkt_cnt", pkt_cnt, 0);

        // ---------------- random traffic, random backpressure ----------------
        drop0 = drop_cnt;
        rdy_rand = 1'b1;
        for (int p = 0; p < 150; p++) begin
            send_pkt($urandom_range(1, DEPTH), $urandom_range(0, 2), 1'b0, 1'b1);
        end
        rdy_rand = 1'b0;
        wait_drain();
        chk("random_no_drops", drop_cnt, 64'(drop0));
        chk("random_pkt_cnt", pkt_cnt, 0);
        chk("no_gaps_in_packets", 64'(gap_cnt), 64'd0);

        // ---------------- reset in the middle of a packet ----------------
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {32'hDEAD, 32'(i)};
            s_tkeep  = 8'hFF;
            s_tlast  = 1'b0;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_tready", s_tready, 0);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_m_tdata", m_tdata, 0);
        chk("midrst_pkt_cnt", pkt_cnt, 0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        beats_out = 0;
        repeat (2) @(posedge clk);
        #1;
        send_pkt(2, 0, 1'b0, 1'b1);
        wait_drain();
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_beats_out", 64'(beats_out), 64'd2);
        chk("midrst_drop_after", drop_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
